ifetch_unit: RTL and testbench

//  Fetch-side consumer of the program counter: reads PC, issues one word read to

---
 rtl/ifetch_unit.sv | 94 +++++++++
 tb/tb_ifetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one word read per fetch over a req/ack handshake
// and holds the returned word in ir until the control unit accepts it.
module ifetch_unit #(
    parameter int unsigned TIMEOUT     = 16,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        pc_wr,
    output logic [31:0] pc_plus4,
    output logic        fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       aligned;

    assign aligned  = (pc[1:0] == 2'b00) || (ALIGN_CHECK == 1'b0);
    // ir_valid is only ever set in VALID, so pc_wr cannot pulse in any other state.
    assign pc_wr    = ir_valid & ir_ready & ~flush & ~rst;
    assign pc_plus4 = imem_addr + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= 32'h0;
            ir        <= 32'h0;
            ir_valid  <= 1'b0;
            fault     <= 1'b0;
            wait_cnt  <= 8'h0;
        end else if (flush) begin
            // A flush discards a coincident ack, so ir keeps its old contents.
            state    <= S_IDLE;
            imem_req <= 1'b0;
            ir_valid <= 1'b0;
            fault    <= 1'b0;
            wait_cnt <= 8'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_en && !fault) begin
                        if (aligned) begin
                            state     <= S_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= {pc[31:2], 2'b00};
                            wait_cnt  <= 8'h0;
                        end else begin
                            fault <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        ir_valid <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= S_VALID;
                    end else if (wait_cnt == LAST_WAIT) begin
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_VALID: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: expected instruction words are queued as ack data
// is driven and popped when ir_valid shows them.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_en;
    logic        flush;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_ready;

    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] ir,        ir2;
    logic        ir_valid,  ir_valid2;
    logic        pc_wr,     pc_wr2;
    logic [31:0] pc_plus4,  pc_plus42;
    logic        fault,     fault2;

    int errors = 0;
    int checks = 0;
    int pcwr_count = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ifetch_unit #(.TIMEOUT(16), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .pc_wr(pc_wr), .pc_plus4(pc_plus4), .fault(fault)
    );

    ifetch_unit #(.TIMEOUT(16), .ALIGN_CHECK(1'b0)) dut_noalign (
        .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir2), .ir_valid(ir_valid2), .ir_ready(ir_ready),
        .pc_wr(pc_wr2), .pc_plus4(pc_plus42), .fault(fault2)
    );

    // Every pc_wr pulse seen at a clock edge is counted so duplicates show up.
    always @(posedge clk) begin
        if (!rst && pc_wr)
            pcwr_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] new_pc, input logic fe);
        pc       = new_pc;
        fetch_en = fe;
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkIr(input string tag);
        int waited = 0;
        logic [31:0] exp;
        while (!ir_valid && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_valid"}, 32'(ir_valid), 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s_queue: observed=empty expected=entry", tag);
        end else begin
            exp = exp_q.pop_front();
            checkOutput(tag, ir, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; pc = 32'h0000_3000; fetch_en = 1'b0; flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; ir_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_req",   32'(imem_req), 32'd0);
        checkOutput("rst_addr",  imem_addr,     32'h0);
        checkOutput("rst_ir",    ir,            32'h0);
        checkOutput("rst_valid", 32'(ir_valid), 32'd0);
        checkOutput("rst_fault", 32'(fault),    32'd0);
        checkOutput("rst_pcwr",  32'(pc_wr),    32'd0);

        $display("[TB] basic fetch with ack in first request cycle");
        applyStimulus(32'h0000_3000, 1'b1);
        checkOutput("t1_req",  32'(imem_req), 32'd1);
        checkOutput("t1_addr", imem_addr,     32'h0000_3000);
        imem_ack = 1'b1; imem_rdata = 32'h2408_0005;
        exp_q.push_back(32'h2408_0005);
        tick();
        imem_ack = 1'b0;
        checkOutput("t1_latency", 32'(ir_valid), 32'd1);
        checkIr("t1_ir");
        checkOutput("t1_req_low", 32'(imem_req), 32'd0);
        checkOutput("t1_plus4",   pc_plus4,      32'h0000_3004);
        checkOutput("t1_nopcwr",  32'(pc_wr),    32'd0);
        ir_ready = 1'b1;
        #1;
        checkOutput("t1_pcwr", 32'(pc_wr), 32'd1);
        tick();
        ir_ready = 1'b0;
        checkOutput("t1_consumed", 32'(ir_valid), 32'd0);
        checkOutput("t1_ir_keep",  ir,            32'h2408_0005);
        checkOutput("t1_pcwr_cnt", pcwr_count,    32'd1);

        $display("[TB] delayed ack with pc changing mid-request");
        applyStimulus(32'h0000_3000, 1'b1);
        pc = 32'h0000_4000;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req) n++;
            checkOutput("t2_addr_hold", imem_addr, 32'h0000_3000);
            tick();
        end
        if (imem_req) n++;
        imem_ack = 1'b1; imem_rdata = 32'h8C09_0004;
        exp_q.push_back(32'h8C09_0004);
        tick();
        imem_ack = 1'b0;
        checkOutput("t2_req_cycles", n, 32'd6);
        checkIr("t2_ir");
        checkOutput("t2_pcwr_cnt", pcwr_count, 32'd1);
        applyStimulus(32'h0000_4000, 1'b1);
        checkOutput("t2_fetch_ignored", 32'(imem_req), 32'd0);
        checkOutput("t2_still_valid",   32'(ir_valid), 32'd1);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        checkOutput("t2_pcwr_cnt2", pcwr_count, 32'd2);

        $display("[TB] request timeout");
        applyStimulus(32'h0000_3000, 1'b1);
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            tick();
        end
        checkOutput("t3_req_cycles", n,           32'd16);
        checkOutput("t3_fault",      32'(fault),  32'd1);
        applyStimulus(32'h0000_3000, 1'b1);
        checkOutput("t3_blocked", 32'(imem_req), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("t3_fault_clr", 32'(fault), 32'd0);

        $display("[TB] misaligned pc");
        applyStimulus(32'h0000_3002, 1'b1);
        checkOutput("t4_fault",      32'(fault),     32'd1);
        checkOutput("t4_req2",       32'(imem_req2), 32'd1);
        checkOutput("t4_addr2",      imem_addr2,     32'h0000_3000);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (imem_req) n++;
            tick();
        end
        checkOutput("t4_never_req", n, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("t4_fault_clr", 32'(fault),     32'd0);
        checkOutput("t4_req2_clr",  32'(imem_req2), 32'd0);

        $display("[TB] pc_plus4 wraparound");
        applyStimulus(32'hFFFF_FFFC, 1'b1);
        checkOutput("t5_addr",  imem_addr, 32'hFFFF_FFFC);
        checkOutput("t5_plus4", pc_plus4,  32'h0000_0000);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        $display("[TB] flush coincident with ack");
        applyStimulus(32'h0000_3000, 1'b1);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; flush = 1'b1;
        #1;
        checkOutput("t6_pcwr", 32'(pc_wr), 32'd0);
        tick();
        imem_ack = 1'b0; flush = 1'b0;
        checkOutput("t6_ir_keep", ir,            32'h8C09_0004);
        checkOutput("t6_valid",   32'(ir_valid), 32'd0);
        checkOutput("t6_req",     32'(imem_req), 32'd0);
        checkOutput("t6_pcwr_cnt", pcwr_count,   32'd2);

        $display("[TB] reset while holding a valid instruction");
        applyStimulus(32'h0000_3000, 1'b1);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        tick();
        imem_ack = 1'b0;
        checkIr("t7_ir");
        ir_ready = 1'b1; rst = 1'b1;
        tick();
        ir_ready = 1'b0; rst = 1'b0;
        checkOutput("t7_ir",    ir,            32'h0);
        checkOutput("t7_valid", 32'(ir_valid), 32'd0);
        checkOutput("t7_addr",  imem_addr,     32'h0);
        checkOutput("t7_plus4", pc_plus4,      32'h0000_0004);
        checkOutput("t7_pcwr_cnt", pcwr_count, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
